// File: rtl/encode_pk_stream.sv
// Byte-serial public-key encoder: emits the 32-byte seed rho, then packs
// canonicalised 12-bit t-coefficients pairwise into 3 bytes each.
module encode_pk_stream #(
    parameter int KYBER_N = 256,
    parameter int KYBER_K = 3,
    parameter int KYBER_Q = 3329,
    parameter int COEF_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [255:0]      rho,
    input  logic [COEF_W-1:0] coef_in,
    input  logic              coef_valid,
    output logic              coef_ready,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | waiting for start
    // RHO   | streaming the 32 latched seed bytes
    // COEF  | accepting coefficients, draining packed bytes
    // FIN   | one-cycle done pulse after the last byte handshake
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RHO  = 2'd1;
    localparam logic [1:0] COEF = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam int NCOEF = KYBER_K * KYBER_N;
    localparam int CW    = $clog2(NCOEF + 1);

    logic [1:0]        state_q;
    logic [255:0]      rho_q;
    logic [4:0]        rho_cnt;
    logic [CW-1:0]     coef_cnt;
    logic [7:0]        fifo_q [3];
    logic [1:0]        fifo_cnt;
    logic [3:0]        nib_q;
    logic [COEF_W-1:0] c_red;
    logic              coef_hs;
    logic              pop;

    // Canonicalise mod Q; inputs never exceed 2Q-1, so one subtract suffices.
    always_comb begin
        c_red = coef_in;
        if (coef_in >= COEF_W'(KYBER_Q)) begin
            c_red = coef_in - COEF_W'(KYBER_Q);
        end
    end

    // Handshake qualifiers and output decode, all from registered state.
    always_comb begin
        coef_ready = (state_q == COEF) && (fifo_cnt == 2'd0) && (coef_cnt < CW'(NCOEF));
        coef_hs    = coef_ready && coef_valid;
        pop        = (state_q == COEF) && (fifo_cnt != 2'd0) && byte_ready;
        busy       = (state_q != IDLE);
        done       = (state_q == FIN);
        byte_valid = 1'b0;
        byte_out   = 8'h00;
        if (state_q == RHO) begin
            byte_valid = 1'b1;
            byte_out   = rho_q[{rho_cnt, 3'b000} +: 8];
        end else if (state_q == COEF && fifo_cnt != 2'd0) begin
            byte_valid = 1'b1;
            byte_out   = fifo_q[0];
        end
    end

    // Frame sequencing: seed latch, byte/coefficient counters and state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rho_q    <= '0;
            rho_cnt  <= '0;
            coef_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rho_q   <= rho;
                        rho_cnt <= '0;
                        state_q <= RHO;
                    end
                end
                RHO: begin
                    if (byte_ready) begin
                        rho_cnt <= rho_cnt + 5'd1;
                        if (rho_cnt == 5'd31) begin
                            coef_cnt <= '0;
                            state_q  <= COEF;
                        end
                    end
                end
                COEF: begin
                    if (coef_hs) begin
                        coef_cnt <= coef_cnt + CW'(1);
                    end
                    if (coef_cnt == CW'(NCOEF) && fifo_cnt == 2'd1 && pop) begin
                        state_q <= FIN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Packed-byte FIFO; pushes only happen when it is empty, so push and pop never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            fifo_q[2] <= '0;
            fifo_cnt  <= '0;
            nib_q     <= '0;
        end else if (state_q != COEF) begin
            fifo_cnt <= '0;
        end else if (coef_hs) begin
            if (!coef_cnt[0]) begin
                fifo_q[0] <= c_red[7:0];
                nib_q     <= c_red[11:8];
                fifo_cnt  <= 2'd1;
            end else begin
                fifo_q[0] <= {c_red[3:0], nib_q};
                fifo_q[1] <= c_red[11:4];
                fifo_cnt  <= 2'd2;
            end
        end else if (pop) begin
            fifo_q[0] <= fifo_q[1];
            fifo_q[1] <= fifo_q[2];
            fifo_q[2] <= '0;
            fifo_cnt  <= fifo_cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_encode_pk_stream.sv
// Bench for encode_pk_stream: golden byte queue built from the packing rules,
// one negedge compare process, random backpressure and coefficient gaps.
module tb_encode_pk_stream;

    localparam int N     = 256;
    localparam int K     = 3;
    localparam int Q     = 3329;
    localparam int NCOEF = K * N;
    localparam int FRAME = 32 + 3 * NCOEF / 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] rho = '0;
    logic [11:0]  coef_in = '0;
    logic         coef_valid = 1'b0;
    logic         coef_ready;
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_ready = 1'b0;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    int       coefs [NCOEF];
    int       cidx = 0;
    bit       coef_hs_pend = 0;
    logic [7:0] expq [$];
    int       hs_cnt = 0;
    int       taken = 0;
    bit       stall_prev = 0;
    logic [7:0] prev_byte = '0;
    bit       last_hs_prev = 0;

    encode_pk_stream #(.KYBER_N(N), .KYBER_K(K), .KYBER_Q(Q), .COEF_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .rho(rho),
        .coef_in(coef_in), .coef_valid(coef_valid), .coef_ready(coef_ready),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Golden frame: seed bytes, then each coefficient pair reduced mod Q and packed LSB-first.
    task automatic build_frame(input logic [255:0] r);
        int a;
        int b;
        expq.delete();
        for (int i = 0; i < 32; i++) expq.push_back(r[8*i +: 8]);
        for (int i = 0; i < NCOEF / 2; i++) begin
            a = coefs[2*i] % Q;
            b = coefs[2*i+1] % Q;
            expq.push_back(8'(a & 255));
            expq.push_back(8'(((b & 15) << 4) | (a >> 8)));
            expq.push_back(8'(b >> 4));
        end
    endtask

    task automatic gen_coefs();
        for (int i = 0; i < NCOEF; i++) begin
            if ($urandom_range(0, 7) == 0) coefs[i] = $urandom_range(Q, 4095);
            else coefs[i] = $urandom_range(0, 4095);
        end
    endtask

    task automatic clear_model();
        hs_cnt = 0; taken = 0; stall_prev = 0; last_hs_prev = 0;
        coef_hs_pend = 0; cidx = 0;
    endtask

    task automatic wait_hs(input int n);
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #2;
            if (hs_cnt >= n) begin ok = 1; break; end
        end
        if (!ok) begin n_tests++; n_fail++; $display("FAIL wait_hs: timeout at %0d expected %0d", hs_cnt, n); end
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk); #2;
            if (done) begin ok = 1; break; end
        end
        if (!ok) begin n_tests++; n_fail++; $display("FAIL wait_done: timeout hs=%0d expected %0d", hs_cnt, FRAME); end
    endtask

    // Input driver: random byte_ready and coefficient gaps, one extra coefficient offered after the last.
    always begin
        @(posedge clk); #1;
        if (coef_hs_pend) begin cidx++; coef_hs_pend = 0; end
        byte_ready = ($urandom_range(0, 1) == 1);
        if (cidx < NCOEF) begin
            coef_in    = 12'(coefs[cidx]);
            coef_valid = ($urandom_range(0, 3) != 0);
        end else begin
            coef_in    = 12'd769;
            coef_valid = 1'b1;
        end
    end

    // Compare process: bytes against golden queue, stall stability, coef_ready gating, done timing.
    always @(negedge clk) begin
        if (!rst) begin
            chk("done", 32'(done), 32'(last_hs_prev));
            if (done) begin
                chk("frame_len", 32'(hs_cnt), 32'(FRAME));
                chk("coefs_taken", 32'(taken), 32'(NCOEF));
                hs_cnt = 0;
                taken  = 0;
            end
            last_hs_prev = 0;
            if (stall_prev) begin
                chk("stall_valid", 32'(byte_valid), 32'd1);
                chk("stall_byte", 32'(byte_out), 32'(prev_byte));
            end
            if (hs_cnt < 32 || taken >= NCOEF || !busy)
                chk("coef_ready_gate", 32'(coef_ready), 32'd0);
            if (coef_valid && coef_ready) begin
                taken++;
                coef_hs_pend = 1;
            end
            if (byte_valid && byte_ready) begin
                if (expq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL byte_extra: got %0h expected no byte", byte_out);
                end else begin
                    chk($sformatf("byte[%0d]", hs_cnt), 32'(byte_out), 32'(expq.pop_front()));
                end
                hs_cnt++;
                if (hs_cnt == FRAME) last_hs_prev = 1;
            end
            stall_prev = byte_valid && !byte_ready;
            prev_byte  = byte_out;
        end
    end

    initial begin
        logic [255:0] rho_inc;
        logic [255:0] rho_rnd;
        for (int i = 0; i < 32; i++) rho_inc[8*i +: 8] = 8'(i);
        for (int i = 0; i < 8; i++) rho_rnd[32*i +: 32] = $urandom;
        gen_coefs();

        repeat (3) @(negedge clk);
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_coef_ready", 32'(coef_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_byte_out", 32'(byte_out), 32'd0);
        rst = 1'b0;

        // Abandoned frame: reset while rho byte 10 is on the wire.
        rho = rho_inc;
        build_frame(rho_inc);
        @(negedge clk); #2; start = 1'b1;
        @(negedge clk); #2; start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_hs(10);
        rst = 1'b1;
        #1;
        chk("midrst_byte_valid", 32'(byte_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        expq.delete();
        clear_model();
        @(negedge clk); @(negedge clk); #2;
        clear_model();
        rst = 1'b0;

        // Frame A: incrementing rho, hand-picked leading coefficients.
        coefs[0] = 'h123; coefs[1] = 'hABC;
        coefs[2] = 3328;  coefs[3] = 1;
        coefs[4] = 3329;  coefs[5] = 4095;
        build_frame(rho_inc);
        chk("model_rho0", 32'(expq[0]), 32'h00);
        chk("model_rho31", 32'(expq[31]), 32'h1F);
        chk("model_p0", 32'(expq[32]), 32'h23);
        chk("model_p1", 32'(expq[33]), 32'hC1);
        chk("model_p2", 32'(expq[34]), 32'hAB);
        chk("model_p3", 32'(expq[35]), 32'h00);
        chk("model_p4", 32'(expq[36]), 32'h1D);
        chk("model_p5", 32'(expq[37]), 32'h00);
        chk("model_p6", 32'(expq[38]), 32'h00);
        chk("model_p7", 32'(expq[39]), 32'hE0);
        chk("model_p8", 32'(expq[40]), 32'h2F);
        chk("model_len", 32'(expq.size()), 32'd1184);
        @(negedge clk); #2; start = 1'b1;
        @(negedge clk); #2; start = 1'b0;
        wait_hs(100);
        rho   = rho_rnd;
        start = 1'b1;
        @(negedge clk); #2; start = 1'b0;
        chk("busy_coef_start", 32'(busy), 32'd1);
        wait_done();

        // Frame B: start held from the done cycle into the first IDLE cycle.
        start = 1'b1;
        rho   = rho_rnd;
        gen_coefs();
        cidx = 0;
        build_frame(rho_rnd);
        @(negedge clk); #2;
        chk("idle_after_done", 32'(busy), 32'd0);
        @(negedge clk); #2; start = 1'b0;
        chk("busy_frame_b", 32'(busy), 32'd1);
        wait_done();
        @(negedge clk); #2;
        chk("idle_end", 32'(busy), 32'd0);
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
